button_conditioner: RTL

Input-conditioning stage between the seven raw board push-buttons and the direction encoder / state-transition logic of the game top level. Each button is synchronised, debounced and edge-detected. Presses are priority-encoded into the 3-bit event code already used by the game, and held in a one-entry event register with a valid/ack handshake. The slow-ticking state machine therefore consumes exactly one event per physical press, however long the button is held.

---
 rtl/game_pkg.sv | 46 ++++
 rtl/btn_debounce.sv | 57 +++++
 rtl/button_conditioner.sv | 76 +++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game constants: event codes, button bit positions and the press
// priority encoder used by the input conditioner and the game state logic.
package game_pkg;

  localparam int NUM_BTN = 7;

  localparam logic [2:0] EVT_NONE     = 3'd0;
  localparam logic [2:0] EVT_RIGHT    = 3'd1;
  localparam logic [2:0] EVT_LEFT     = 3'd2;
  localparam logic [2:0] EVT_DOWN     = 3'd3;
  localparam logic [2:0] EVT_UP       = 3'd4;
  localparam logic [2:0] EVT_DECISION = 3'd5;
  localparam logic [2:0] EVT_RED_RST  = 3'd6;
  localparam logic [2:0] EVT_BLUE_RST = 3'd7;

  localparam int BTN_RIGHT    = 0;
  localparam int BTN_LEFT     = 1;
  localparam int BTN_DOWN     = 2;
  localparam int BTN_UP       = 3;
  localparam int BTN_DECISION = 4;
  localparam int BTN_RED_RST  = 5;
  localparam int BTN_BLUE_RST = 6;

  // Later assignments override earlier ones, so the highest code wins.
  function automatic logic [2:0] evt_encode(input logic [NUM_BTN-1:0] press);
    logic [2:0] code;
    code = EVT_NONE;
    if (press[BTN_RIGHT])    code = EVT_RIGHT;
    if (press[BTN_LEFT])     code = EVT_LEFT;
    if (press[BTN_DOWN])     code = EVT_DOWN;
    if (press[BTN_UP])       code = EVT_UP;
    if (press[BTN_DECISION]) code = EVT_DECISION;
    if (press[BTN_RED_RST])  code = EVT_RED_RST;
    if (press[BTN_BLUE_RST]) code = EVT_BLUE_RST;
    return code;
  endfunction

  function automatic logic multi_press(input logic [NUM_BTN-1:0] press);
    return (press & (press - NUM_BTN'(1))) != '0;
  endfunction

  function automatic logic is_reset_code(input logic [2:0] code);
    return (code == EVT_RED_RST) || (code == EVT_BLUE_RST);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: two-flop synchroniser, stability counter, debounced level and
// a registered pulse that coincides with the first cycle the level reads 1.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic press
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      // Input has differed long enough: adopt it, pulse only on a rising level.
      level_d = sync2_q;
      press_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the seven game buttons and turns presses into single events held
// in a one-entry register with a valid/ack handshake.
module button_conditioner
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic               evt_valid,
  output logic [2:0]         evt_code,
  input  logic               evt_ack,
  output logic               evt_dropped
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .level(btn_level[i]),
      .press(btn_press[i])
    );
  end

  logic       evt_valid_q, evt_valid_d;
  logic [2:0] evt_code_q, evt_code_d;
  logic       evt_dropped_q, evt_dropped_d;
  logic [2:0] new_code;
  logic       any_press;

  always_comb begin
    new_code      = evt_encode(btn_press);
    any_press     = |btn_press;
    evt_valid_d   = evt_valid_q;
    evt_code_d    = evt_code_q;
    evt_dropped_d = multi_press(btn_press);
    if (!evt_valid_q) begin
      if (any_press) begin
        evt_valid_d = 1'b1;
        evt_code_d  = new_code;
      end
    end else if (evt_ack) begin
      if (any_press) evt_code_d = new_code;
      else           evt_valid_d = 1'b0;
    end else if (any_press) begin
      // Register full: only a reset event may displace the pending one.
      evt_dropped_d = 1'b1;
      if (is_reset_code(new_code)) evt_code_d = new_code;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      evt_valid_q   <= 1'b0;
      evt_code_q    <= EVT_NONE;
      evt_dropped_q <= 1'b0;
    end else begin
      evt_valid_q   <= evt_valid_d;
      evt_code_q    <= evt_code_d;
      evt_dropped_q <= evt_dropped_d;
    end
  end

  assign evt_valid   = evt_valid_q;
  assign evt_code    = evt_code_q;
  assign evt_dropped = evt_dropped_q;

endmodule
